// File: rtl/pipo_pkg.sv
// Shared types and defaults for the parallel-in/parallel-out register.
package pipo_pkg;

    localparam int PIPO_WIDTH_DEFAULT = 4;

    typedef logic [PIPO_WIDTH_DEFAULT-1:0] pipo_word_t;

endpackage

// File: rtl/pipo_bit.sv
// Single D flip-flop with synchronous active-high clear.
module pipo_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipo.sv
// WIDTH-bit holding register: loads a every edge, clears on rst.
module pipo
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pipo_bit u_bit (
            .clk (clk),
            .rst (rst),
            .d   (a[i]),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_pipo.sv
// Directed bench for pipo at WIDTH 4, 1 and 16.
module tb_pipo;
    import pipo_pkg::*;

    logic        clk;
    logic        rst;
    pipo_word_t  a4;
    pipo_word_t  q4;
    logic [0:0]  a1;
    logic [0:0]  q1;
    logic [15:0] a16;
    logic [15:0] q16;

    int total;
    int bad;

    pipo u_dut4 (
        .clk (clk),
        .rst (rst),
        .a   (a4),
        .q   (q4)
    );

    pipo #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .a   (a1),
        .q   (q1)
    );

    pipo #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .a   (a16),
        .q   (q16)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] prev16;
        logic [0:0]  prev1;
        total = 0;
        bad   = 0;

        rst = 1'b1;
        a4  = 4'b1101;
        a1  = 1'b1;
        a16 = 16'hffff;

        after_edge();
        check("reset_q4", 64'(q4), 64'h0);
        check("reset_q1", 64'(q1), 64'h0);
        check("reset_q16", 64'(q16), 64'h0);

        #49 rst = 1'b0;
        @(negedge clk);
        check("capture_not_before", 64'(q4), 64'h0);
        after_edge();
        check("capture", 64'(q4), 64'hd);

        @(negedge clk);
        a4 = 4'b1000;
        #50;
        check("update_hold", 64'(q4), 64'hd);
        after_edge();
        check("update", 64'(q4), 64'h8);

        @(negedge clk);
        rst = 1'b1;
        after_edge();
        check("midrst_edge1", 64'(q4), 64'h0);
        after_edge();
        check("midrst_edge2", 64'(q4), 64'h0);

        @(negedge clk);
        rst = 1'b0;
        after_edge();
        check("release", 64'(q4), 64'h8);
        after_edge();
        check("release_stable", 64'(q4), 64'h8);

        prev16 = a16;
        prev1  = a1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a16 = 16'(1) << i;
            a1  = 1'(i % 2 == 0);
            check("w16_hold", 64'(q16), 64'(prev16));
            check("w1_hold", 64'(q1), 64'(prev1));
            prev16 = a16;
            prev1  = a1;
            after_edge();
            check("w16_walk", 64'(q16), 64'(prev16));
            check("w1_walk", 64'(q1), 64'(prev1));
        end

        @(negedge clk);
        a16 = 16'hffff;
        a1  = 1'b1;
        a4  = 4'b1111;
        rst = 1'b1;
        after_edge();
        check("w16_clear", 64'(q16), 64'h0);
        check("w1_clear", 64'(q1), 64'h0);
        check("w4_clear", 64'(q4), 64'h0);

        @(negedge clk);
        rst = 1'b0;
        after_edge();
        check("w16_reload", 64'(q16), 64'hffff);
        check("w1_reload", 64'(q1), 64'h1);
        check("w4_reload", 64'(q4), 64'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
